// File: rtl/cross_bar_req_queue_if.sv
// Bundle of client-side, response and crossbar-master signals for
// cross_bar_req_queue.
//   slave  : view taken by the queue (drives in_ready, rsp_*, master_*, count)
//   master : view taken by the environment (drives in_*, master_ack/rdata)
interface cross_bar_req_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic              in_cmd;
    logic [DATA_W-1:0] in_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              master_req;
    logic [ADDR_W-1:0] master_addr;
    logic              master_cmd;
    logic [DATA_W-1:0] master_wdata;
    logic              master_ack;
    logic [DATA_W-1:0] master_rdata;

    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, in_addr, in_cmd, in_wdata, master_ack, master_rdata,
        output in_ready, rsp_valid, rsp_rdata, rsp_err,
               master_req, master_addr, master_cmd, master_wdata, count
    );

    modport master (
        output in_valid, in_addr, in_cmd, in_wdata, master_ack, master_rdata,
        input  in_ready, rsp_valid, rsp_rdata, rsp_err,
               master_req, master_addr, master_cmd, master_wdata, count
    );
endinterface

// File: rtl/cross_bar_req_queue.sv
// Request queue in front of a crossbar master port. Client transactions are
// buffered in a DEPTH-entry FIFO and issued one at a time on the master port;
// each issue completes on master_ack or, if TIMEOUT > 0, after TIMEOUT
// unacknowledged cycles, and produces a one-cycle response in order.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous active-high reset
//   bus    : cross_bar_req_queue_if.slave
//            in_valid/in_ready/in_addr/in_cmd/in_wdata   client push
//            rsp_valid/rsp_rdata/rsp_err                 completion pulse
//            master_req/addr/cmd/wdata, master_ack/rdata crossbar master port
//            count                                       entries incl. in-flight
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no request on the master port; issues the head if count > 0
// S_REQ  | master_req high, waiting for ack or timeout
module cross_bar_req_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input logic                     clk,
    input logic                     reset,
    cross_bar_req_queue_if.slave    bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
    localparam logic              TO_EN     = (TIMEOUT > 0);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    logic [ADDR_W-1:0] addr_mem_q  [DEPTH];
    logic              cmd_mem_q   [DEPTH];
    logic [DATA_W-1:0] wdata_mem_q [DEPTH];

    state_t            state_q,        state_d;
    logic [PTR_W-1:0]  wr_ptr_q,       wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,       rd_ptr_d;
    logic [CNT_W-1:0]  count_q,        count_d;
    logic [WAIT_W-1:0] wait_q,         wait_d;
    logic              master_req_q,   master_req_d;
    logic [ADDR_W-1:0] master_addr_q,  master_addr_d;
    logic              master_cmd_q,   master_cmd_d;
    logic [DATA_W-1:0] master_wdata_q, master_wdata_d;
    logic              rsp_valid_q,    rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q,    rsp_rdata_d;
    logic              rsp_err_q,      rsp_err_d;

    logic in_ready;
    logic push;
    logic pop;

    // in_ready looks only at the registered count: a pop in the same cycle
    // does not open a slot until the next cycle.
    assign in_ready = (count_q < DEPTH_C);
    assign push     = bus.in_valid && in_ready && !reset;

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        master_req_d   = master_req_q;
        master_addr_d  = master_addr_q;
        master_cmd_d   = master_cmd_q;
        master_wdata_d = master_wdata_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = '0;
        rsp_err_d      = 1'b0;
        pop            = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // master_ack is deliberately not looked at here.
                if (count_q != '0) begin
                    master_addr_d  = addr_mem_q[rd_ptr_q];
                    master_cmd_d   = cmd_mem_q[rd_ptr_q];
                    master_wdata_d = wdata_mem_q[rd_ptr_q];
                    master_req_d   = 1'b1;
                    wait_d         = '0;
                    state_d        = S_REQ;
                end
            end
            S_REQ: begin
                // Ack is checked first so an ack on the timeout cycle wins.
                if (bus.master_ack) begin
                    pop          = 1'b1;
                    master_req_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = master_cmd_q ? '0 : bus.master_rdata;
                    state_d      = S_IDLE;
                end else if (TO_EN && (wait_q == WAIT_LAST)) begin
                    pop          = 1'b1;
                    master_req_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            wait_q         <= '0;
            master_req_q   <= 1'b0;
            master_addr_q  <= '0;
            master_cmd_q   <= 1'b0;
            master_wdata_q <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            wait_q         <= wait_d;
            master_req_q   <= master_req_d;
            master_addr_q  <= master_addr_d;
            master_cmd_q   <= master_cmd_d;
            master_wdata_q <= master_wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q]  <= bus.in_addr;
            cmd_mem_q[wr_ptr_q]   <= bus.in_cmd;
            wdata_mem_q[wr_ptr_q] <= bus.in_wdata;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.master_req   = master_req_q;
    assign bus.master_addr  = master_addr_q;
    assign bus.master_cmd   = master_cmd_q;
    assign bus.master_wdata = master_wdata_q;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_cross_bar_req_queue.sv
module tb_cross_bar_req_queue;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cross_bar_req_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cross_bar_req_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              cmd;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [ADDR_W-1:0] a, input logic c, input logic [DATA_W-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_cmd   = c;
        bus.in_wdata = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_txn(input logic [ADDR_W-1:0] a, input logic c,
                              input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] rd,
                              input logic err);
        exp_req.push_back('{a, c, w});
        exp_rsp.push_back('{rd, err});
    endtask

    // Waits (bounded) for master_req, waits dly more cycles, then acks one cycle.
    task automatic serve(input logic [DATA_W-1:0] rd, input int dly);
        int n;
        n = 0;
        while (!bus.master_req && n < 50) begin
            tick();
            n++;
        end
        check("serve_req_seen", 32'(bus.master_req), 32'd1);
        if (bus.master_req) begin
            repeat (dly) tick();
            bus.master_ack   = 1'b1;
            bus.master_rdata = rd;
            tick();
            bus.master_ack   = 1'b0;
            bus.master_rdata = '0;
        end
    endtask

    // Request monitor: each new issue must match the next expected entry, and
    // the master payload must hold steady while master_req stays high.
    logic              prev_req  = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic              prev_cmd  = 1'b0;
    logic [DATA_W-1:0] prev_wd   = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (bus.master_req && !prev_req) begin
                if (exp_req.size() == 0) begin
                    check("unexpected_master_req", 32'd1, 32'd0);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    check("master_addr", bus.master_addr, e.addr);
                    check("master_cmd", 32'(bus.master_cmd), 32'(e.cmd));
                    check("master_wdata", bus.master_wdata, e.wdata);
                end
            end else if (bus.master_req && prev_req) begin
                check("master_addr_stable", bus.master_addr, prev_addr);
                check("master_cmd_stable", 32'(bus.master_cmd), 32'(prev_cmd));
                check("master_wdata_stable", bus.master_wdata, prev_wd);
            end
            prev_req  = bus.master_req;
            prev_addr = bus.master_addr;
            prev_cmd  = bus.master_cmd;
            prev_wd   = bus.master_wdata;
        end
    end

    // Response monitor: every rsp_valid pulse pops the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                check("unexpected_rsp_valid", 32'd1, 32'd0);
            end else begin
                rsp_t r;
                r = exp_rsp.pop_front();
                check("rsp_rdata", bus.rsp_rdata, r.rdata);
                check("rsp_err", 32'(bus.rsp_err), 32'(r.err));
            end
        end
    end

    initial begin
        int n;
        reset            = 1'b1;
        bus.in_valid     = 1'b1;   // must be ignored while reset is high
        bus.in_addr      = 32'hBAD0;
        bus.in_cmd       = 1'b0;
        bus.in_wdata     = '0;
        bus.master_ack   = 1'b0;
        bus.master_rdata = '0;

        repeat (3) tick();
        bus.in_valid = 1'b0;
        check("rst_master_req", 32'(bus.master_req), 32'd0);
        check("rst_master_addr", bus.master_addr, 32'd0);
        check("rst_master_wdata", bus.master_wdata, 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_count", 32'(bus.count), 32'd0);

        // Single read: push at t, req at t+2, ack at t+4, response at t+5.
        expect_txn(32'h10, 1'b0, 32'h0, 32'hCAFE, 1'b0);
        offer(32'h10, 1'b0, 32'h0);          // now t+1
        check("single_count", 32'(bus.count), 32'd1);
        check("single_req_t1", 32'(bus.master_req), 32'd0);
        tick();                              // t+2
        check("single_req_t2", 32'(bus.master_req), 32'd1);
        tick();                              // t+3
        tick();                              // t+4
        bus.master_ack   = 1'b1;
        bus.master_rdata = 32'hCAFE;
        tick();                              // t+5
        bus.master_ack   = 1'b0;
        bus.master_rdata = '0;
        check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_rsp_rdata", bus.rsp_rdata, 32'hCAFE);
        check("single_req_dropped", 32'(bus.master_req), 32'd0);
        check("single_count_after", 32'(bus.count), 32'd0);
        tick();
        check("single_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        check("hold_master_addr", bus.master_addr, 32'h10);

        // Ack while idle must be ignored.
        bus.master_ack   = 1'b1;
        bus.master_rdata = 32'hDEAD;
        tick();
        tick();
        bus.master_ack   = 1'b0;
        bus.master_rdata = '0;
        check("idle_ack_no_rsp", 32'(bus.rsp_valid), 32'd0);
        check("idle_ack_no_req", 32'(bus.master_req), 32'd0);

        // Ordering: write A, read B, write C, each acked one cycle after issue,
        // with a single-cycle master_req gap between them.
        expect_txn(32'h100, 1'b1, 32'hA1, 32'h0, 1'b0);
        expect_txn(32'h200, 1'b0, 32'h0, 32'hBEEF, 1'b0);
        expect_txn(32'h300, 1'b1, 32'hC3, 32'h0, 1'b0);
        offer(32'h100, 1'b1, 32'hA1);
        offer(32'h200, 1'b0, 32'h0);
        offer(32'h300, 1'b1, 32'hC3);
        serve(32'h7777, 1);                  // write: rdata must read back 0
        check("gap_ab", 32'(bus.master_req), 32'd0);
        tick();
        check("req_b", 32'(bus.master_req), 32'd1);
        serve(32'hBEEF, 1);
        check("gap_bc", 32'(bus.master_req), 32'd0);
        tick();
        check("req_c", 32'(bus.master_req), 32'd1);
        serve(32'h8888, 1);
        check("order_count_empty", 32'(bus.count), 32'd0);
        repeat (2) tick();

        // Fill: five back-to-back writes, no ack; the fifth must be refused.
        for (int i = 0; i < 4; i++)
            expect_txn(32'h400 + 32'(i), 1'b1, 32'hF0 + 32'(i), 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("fill_in_ready_low", 32'(bus.in_ready), 32'd0);
            offer(32'h400 + 32'(i), 1'b1, 32'hF0 + 32'(i));
        end
        check("fill_count", 32'(bus.count), 32'd4);
        check("fill_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 4; i++) serve(32'h5555, 0);
        tick();
        check("fill_drained", 32'(bus.count), 32'd0);
        repeat (2) tick();

        // Timeout: no ack, master_req high for exactly TIMEOUT cycles.
        expect_txn(32'h40, 1'b0, 32'h0, 32'h0, 1'b1);
        offer(32'h40, 1'b0, 32'h0);
        tick();
        check("to_req_start", 32'(bus.master_req), 32'd1);
        n = 0;
        while (bus.master_req && n < 20) begin
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'd8);
        check("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("to_rsp_err", 32'(bus.rsp_err), 32'd1);
        check("to_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("to_count", 32'(bus.count), 32'd0);
        repeat (2) tick();

        // Ack in the 8th request cycle wins over the timeout.
        expect_txn(32'h50, 1'b0, 32'h0, 32'h1234, 1'b0);
        offer(32'h50, 1'b0, 32'h0);
        tick();                              // request cycle 1
        check("ato_req_start", 32'(bus.master_req), 32'd1);
        repeat (7) tick();                   // request cycle 8
        check("ato_req_cycle8", 32'(bus.master_req), 32'd1);
        bus.master_ack   = 1'b1;
        bus.master_rdata = 32'h1234;
        tick();
        bus.master_ack   = 1'b0;
        bus.master_rdata = '0;
        check("ato_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("ato_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("ato_rsp_rdata", bus.rsp_rdata, 32'h1234);
        repeat (2) tick();

        // Reset with one in flight and three queued: nothing completes.
        exp_req.push_back('{32'h600, 1'b1, 32'h60});
        for (int i = 0; i < 4; i++) offer(32'h600 + 32'(i), 1'b1, 32'h60 + 32'(i));
        check("mid_count", 32'(bus.count), 32'd4);
        check("mid_req", 32'(bus.master_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_req", 32'(bus.master_req), 32'd0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (3) tick();
        check("mid_rst_stays_idle", 32'(bus.master_req), 32'd0);

        // Recovery after reset.
        expect_txn(32'h77, 1'b1, 32'h99, 32'h0, 1'b0);
        offer(32'h77, 1'b1, 32'h99);
        serve(32'h1111, 0);

        n = 0;
        while ((exp_rsp.size() != 0 || exp_req.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        tick();
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        check("req_queue_drained", 32'(exp_req.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1);
    end
endmodule
